// File: rtl/paralelo_serial_phy_tx.sv
// paralelo_serial_phy_tx
//   Byte-to-serial transmitter for the PHY TX lane. Bytes arrive over a valid/ready
//   handshake and leave MSB-first, one bit per clk_32f. After reset the lane sends
//   N_BC COMMA characters so the receiver can align. From then on every byte slot
//   that has no valid data carries a filler COMMA.
// Ports
//   clk_32f         in   bit clock, all state on posedge
//   default_values  in   asynchronous active-high reset
//   data_in[7:0]    in   byte to transmit
//   valid_in        in   data_in holds a byte to send
//   ready_out       out  byte slot open; transfer when valid_in & ready_out at posedge
//   data_out        out  serial bit stream, MSB first
//   active_out      out  training complete, data path open
//   idle_out        out  current byte slot carries a filler COMMA
//   err_k_out       out  1-cycle pulse: an accepted data byte equalled COMMA
module paralelo_serial_phy_tx #(
  parameter logic [7:0]  COMMA = 8'hBC,
  parameter int unsigned N_BC  = 4
) (
  input  logic       clk_32f,
  input  logic       default_values,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out,
  output logic       idle_out,
  output logic       err_k_out
);

  localparam int unsigned BcW = $clog2(N_BC + 1);
  localparam logic [BcW-1:0] BcMax = BcW'(N_BC);

  localparam logic [0:0] STATE_TRAIN = 1'b0;
  localparam logic [0:0] STATE_RUN   = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     sr_q, sr_d;
  logic [BcW-1:0] bc_cnt_q, bc_cnt_d;
  logic           ready_d, active_d, idle_d, err_k_d;
  logic           load, accept;

  // Load slot is the last bit of the current byte; the next byte enters sr at that edge.
  assign load   = (bit_cnt_q == 3'd7);
  // ready_out is only ever high in a RUN load slot, so this is the whole handshake.
  assign accept = valid_in & ready_out;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    sr_d      = {sr_q[6:0], 1'b0};
    bc_cnt_d  = bc_cnt_q;
    active_d  = active_out;
    idle_d    = idle_out;
    err_k_d   = 1'b0;
    if (load) begin
      if (state_q == STATE_TRAIN) begin
        sr_d = COMMA;
        if (bc_cnt_q < BcMax) begin
          bc_cnt_d = bc_cnt_q + BcW'(1);
        end
        if (bc_cnt_d == BcMax) begin
          state_d  = STATE_RUN;
          active_d = 1'b1;
        end
      end else if (accept) begin
        sr_d    = data_in;
        idle_d  = 1'b0;
        // Sent unchanged; flagged so upstream can see it fed a K character.
        err_k_d = (data_in == COMMA);
      end else begin
        sr_d   = COMMA;
        idle_d = 1'b1;
      end
    end
    // Registered ready: high in the cycle whose bit_cnt will be 7 while in RUN.
    ready_d = (state_d == STATE_RUN) && (bit_cnt_d == 3'd7);
  end

  always_ff @(posedge clk_32f or posedge default_values) begin
    if (default_values) begin
      state_q    <= STATE_TRAIN;
      bit_cnt_q  <= 3'd7;
      sr_q       <= 8'h00;
      bc_cnt_q   <= '0;
      ready_out  <= 1'b0;
      active_out <= 1'b0;
      idle_out   <= 1'b0;
      err_k_out  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      bc_cnt_q   <= bc_cnt_d;
      ready_out  <= ready_d;
      active_out <= active_d;
      idle_out   <= idle_d;
      err_k_out  <= err_k_d;
    end
  end

  assign data_out = sr_q[7];

endmodule

// File: tb/tb_paralelo_serial_phy_tx.sv
// Directed bench for paralelo_serial_phy_tx. Inputs are driven and outputs sampled
// on the falling edge; each byte slot is checked bit by bit against hand-set values.
module tb_paralelo_serial_phy_tx;

  logic       clk_32f = 1'b0;
  logic       default_values = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, data_out, active_out, idle_out, err_k_out;

  int n_checks = 0;
  int n_pass   = 0;

  paralelo_serial_phy_tx dut (
    .clk_32f       (clk_32f),
    .default_values(default_values),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .data_out      (data_out),
    .active_out    (active_out),
    .idle_out      (idle_out),
    .err_k_out     (err_k_out)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " data_out"},   {7'd0, data_out},   8'd0);
    check({tag, " ready_out"},  {7'd0, ready_out},  8'd0);
    check({tag, " active_out"}, {7'd0, active_out}, 8'd0);
    check({tag, " idle_out"},   {7'd0, idle_out},   8'd0);
    check({tag, " err_k_out"},  {7'd0, err_k_out},  8'd0);
  endtask

  // One 8-cycle byte slot. ready is expected only in the last cycle (rdy_end).
  task automatic run_slot(input string tag, input logic [7:0] bexp, input logic act,
                          input logic idl, input logic errk, input logic rdy_end);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk_32f);
      check($sformatf("%s bit%0d data", tag, b), {7'd0, data_out}, {7'd0, bexp[7-b]});
      check($sformatf("%s bit%0d ready", tag, b), {7'd0, ready_out},
            {7'd0, (b == 7) ? rdy_end : 1'b0});
      check($sformatf("%s bit%0d active", tag, b), {7'd0, active_out}, {7'd0, act});
      check($sformatf("%s bit%0d idle", tag, b), {7'd0, idle_out}, {7'd0, idl});
      check($sformatf("%s bit%0d errk", tag, b), {7'd0, err_k_out},
            {7'd0, (b == 0) ? errk : 1'b0});
    end
  endtask

  // Four training commas; ready opens only in the final cycle of the 4th slot.
  task automatic run_training(input string tag);
    for (int s = 0; s < 4; s++) begin
      run_slot($sformatf("%s train%0d", tag, s), 8'hBC, (s == 3), 1'b0, 1'b0, (s == 3));
    end
  endtask

  initial begin
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk_32f);
    check_all_zero("reset clocked");

    // Valid data presented during training must be held off until RUN.
    data_in  = 8'hA5;
    valid_in = 1'b1;
    default_values = 1'b0;
    run_training("t1");

    run_slot("a5 0", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    run_slot("a5 1", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);

    data_in = 8'h3C;
    run_slot("3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    valid_in = 1'b0;
    run_slot("fill 0", 8'hBC, 1'b1, 1'b1, 1'b0, 1'b1);

    data_in  = 8'hBC;
    valid_in = 1'b1;
    run_slot("k data", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
    valid_in = 1'b0;
    run_slot("fill 1", 8'hBC, 1'b1, 1'b1, 1'b0, 1'b1);

    // Abort 8'hF0 after its 4th bit with an asynchronous reset.
    data_in  = 8'hF0;
    valid_in = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk_32f);
      check($sformatf("f0 bit%0d data", b), {7'd0, data_out}, 8'd1);
    end
    valid_in = 1'b0;
    #2 default_values = 1'b1;
    #1 check_all_zero("async reset");
    repeat (2) @(negedge clk_32f);
    check_all_zero("held reset");
    default_values = 1'b0;
    run_training("t2");
    run_slot("fill 2", 8'hBC, 1'b1, 1'b1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got no finish, expected finish");
    $fatal(1);
  end

endmodule
